// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if
// D-stage hazard bus: decoded source/destination fields from the decoder
// and the stall / forward-select / counter responses of hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int STAGES = 3,
  parameter int TW     = 3,
  parameter int AW     = 5,
  parameter int CNT_W  = 32,
  parameter int FSW    = $clog2(STAGES + 1)
);
  // D-stage instruction description
  logic             d_valid;
  logic [AW-1:0]    d_rs;
  logic [AW-1:0]    d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic [TW-1:0]    d_tuse_rs;
  logic [TW-1:0]    d_tuse_rt;
  logic             d_we;
  logic [AW-1:0]    d_a3;
  logic [TW-1:0]    d_tnew;
  logic             d_md;
  // Pipeline status
  logic             md_busy;
  logic             flush;
  // Responses
  logic             stall;
  logic [FSW-1:0]   fwd_rs_sel;
  logic [FSW-1:0]   fwd_rt_sel;
  logic [CNT_W-1:0] stall_cnt;

  // Decoder / pipeline side
  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
    output d_we, d_a3, d_tnew, d_md, md_busy, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
    input  d_we, d_a3, d_tnew, d_md, md_busy, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// Shadow scoreboard of in-flight instructions past D. Produces the F/D stall
// (with E bubble), the D-stage forward selects and the mult/div interlock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int STAGES = 3,
  parameter int TW     = 3,
  parameter int AW     = 5,
  parameter int CNT_W  = 32,
  parameter int FSW    = $clog2(STAGES + 1)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  hazard_ctrl_if.slave     bus
);

  localparam logic [TW-1:0]    c_TNEW_ONE = TW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // Scoreboard: entry 0 = E, entry STAGES-1 = oldest
  logic [STAGES-1:0] v_q,    v_d;
  logic [STAGES-1:0] we_q,   we_d;
  logic [AW-1:0]     a3_q   [STAGES];
  logic [AW-1:0]     a3_d   [STAGES];
  logic [TW-1:0]     tnew_q [STAGES];
  logic [TW-1:0]     tnew_d [STAGES];
  // Mult/div flag of the instruction currently in E
  logic              md_e_q, md_e_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              w_rs_hit, w_rt_hit;
  logic [TW-1:0]     w_rs_tnew, w_rt_tnew;
  logic [FSW-1:0]    w_rs_idx, w_rt_idx;
  logic              w_stall_rs, w_stall_rt, w_md_stall, w_stall;
  logic [FSW-1:0]    w_fwd_rs, w_fwd_rt;

  // Youngest-match lookup per source, then stall / forward decisions
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rt_hit  = 1'b0;
    w_rs_tnew = '0;
    w_rt_tnew = '0;
    w_rs_idx  = '0;
    w_rt_idx  = '0;
    // Scan oldest to youngest so the youngest match is the one left standing
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (v_q[k] && we_q[k] && (a3_q[k] == bus.d_rs)) begin
        w_rs_hit  = 1'b1;
        w_rs_tnew = tnew_q[k];
        w_rs_idx  = FSW'(k + 1);
      end
      if (v_q[k] && we_q[k] && (a3_q[k] == bus.d_rt)) begin
        w_rt_hit  = 1'b1;
        w_rt_tnew = tnew_q[k];
        w_rt_idx  = FSW'(k + 1);
      end
    end
    // $0 is hardwired zero and unread sources carry no dependence
    w_rs_hit = w_rs_hit && (bus.d_rs != '0) && bus.d_use_rs;
    w_rt_hit = w_rt_hit && (bus.d_rt != '0) && bus.d_use_rt;

    w_stall_rs = w_rs_hit && (w_rs_tnew > bus.d_tuse_rs);
    w_stall_rt = w_rt_hit && (w_rt_tnew > bus.d_tuse_rt);
    // A match whose result is not ready yet but not needed yet is left to
    // the downstream stage's own forwarding: select 0 here.
    w_fwd_rs = (w_rs_hit && (w_rs_tnew == '0)) ? w_rs_idx : '0;
    w_fwd_rt = (w_rt_hit && (w_rt_tnew == '0)) ? w_rt_idx : '0;

    w_md_stall = bus.d_valid && bus.d_md && (bus.md_busy || (v_q[0] && md_e_q));
    w_stall    = bus.d_valid && (w_stall_rs || w_stall_rt || w_md_stall);
  end

  // Next scoreboard contents: shift every cycle, age tnew, bubble on stall/flush
  always_comb begin
    v_d    = '0;
    we_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      a3_d[k]   = '0;
      tnew_d[k] = '0;
    end
    v_d[0]    = bus.d_valid && !w_stall && !bus.flush;
    we_d[0]   = bus.d_we;
    a3_d[0]   = bus.d_a3;
    tnew_d[0] = bus.d_tnew;
    md_e_d    = bus.d_md;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]    = v_q[k-1] && !bus.flush;
      we_d[k]   = we_q[k-1];
      a3_d[k]   = a3_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - c_TNEW_ONE);
    end
    stall_cnt_d = w_stall ? (stall_cnt_q + c_CNT_ONE) : stall_cnt_q;
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_entry
      // Scoreboard entry register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q[k]    <= 1'b0;
          we_q[k]   <= 1'b0;
          a3_q[k]   <= '0;
          tnew_q[k] <= '0;
        end else begin
          v_q[k]    <= v_d[k];
          we_q[k]   <= we_d[k];
          a3_q[k]   <= a3_d[k];
          tnew_q[k] <= tnew_d[k];
        end
      end
    end
  endgenerate

  // E-stage mult/div flag and stall performance counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_e_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_e_q      <= md_e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall      = w_stall;
  assign bus.fwd_rs_sel = w_fwd_rs;
  assign bus.fwd_rt_sel = w_fwd_rt;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// Directed scenarios for hazard_ctrl; expected responses are queued by the
// driver and compared by an independent negedge monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int STAGES = 3;
  localparam int TW     = 3;
  localparam int AW     = 5;
  localparam int CNT_W  = 32;
  localparam int FSW    = 2;

  logic clk;
  logic reset;

  hazard_ctrl_if #(.STAGES(STAGES), .TW(TW), .AW(AW), .CNT_W(CNT_W), .FSW(FSW)) bus ();

  hazard_ctrl #(.STAGES(STAGES), .TW(TW), .AW(AW), .CNT_W(CNT_W), .FSW(FSW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d @%0t", nm, fld, act, req, $time);
    end
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, "stall",     32'(bus.stall),      32'(e.stall));
      check(nm, "fwd_rs",    32'(bus.fwd_rs_sel), 32'(e.frs));
      check(nm, "fwd_rt",    32'(bus.fwd_rt_sel), 32'(e.frt));
      check(nm, "stall_cnt", bus.stall_cnt,       e.cnt);
    end
  end

  // Queue the expectation for the inputs just applied, then advance a cycle
  task automatic go(input string nm, input logic es, input logic [1:0] ers,
                    input logic [1:0] ert, input logic [31:0] ecnt);
    exp_t e;
    e.stall = es; e.frs = ers; e.frt = ert; e.cnt = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.d_valid = 1'b0; bus.d_rs = '0; bus.d_rt = '0;
    bus.d_use_rs = 1'b0; bus.d_use_rt = 1'b0;
    bus.d_tuse_rs = '0; bus.d_tuse_rt = '0;
    bus.d_we = 1'b0; bus.d_a3 = '0; bus.d_tnew = '0; bus.d_md = 1'b0;
  endtask

  task automatic ins(input int rs, input int rt, input logic urs, input logic urt,
                     input int trs, input int trt, input logic we, input int a3,
                     input int tnew, input logic md);
    bus.d_valid = 1'b1;
    bus.d_rs = AW'(rs); bus.d_rt = AW'(rt);
    bus.d_use_rs = urs; bus.d_use_rt = urt;
    bus.d_tuse_rs = TW'(trs); bus.d_tuse_rt = TW'(trt);
    bus.d_we = we; bus.d_a3 = AW'(a3); bus.d_tnew = TW'(tnew); bus.d_md = md;
  endtask

  initial begin
    reset = 1'b1;
    bus.md_busy = 1'b0;
    bus.flush   = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset state: only the md_busy path can raise stall
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); bus.md_busy = 1'b1;
    go("rst_md",   1, 0, 0, 0);
    idle(); bus.md_busy = 1'b0; reset = 1'b0;
    go("rst_idle", 0, 0, 0, 0);

    // Load-use, tuse=1: one stall cycle
    ins(0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
    go("lw1",      0, 0, 0, 0);
    ins(1, 7, 1, 1, 1, 1, 1, 4, 1, 0);
    go("lu_stall", 1, 0, 0, 0);
    go("lu_go",    0, 0, 0, 1);

    // ALU result to branch (tuse=0): stall then forward from M / W
    ins(0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
    go("addu2",    0, 0, 0, 1);
    ins(2, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    go("beq_stl",  1, 0, 2, 1);
    go("beq_fwd",  0, 2, 3, 2);

    // $0 is never a hazard
    ins(0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
    go("wr0",      0, 0, 0, 2);
    ins(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    go("rd0",      0, 0, 0, 2);

    // Youngest writer governs
    ins(0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    go("ori3",     0, 0, 0, 2);
    ins(0, 0, 0, 0, 0, 0, 1, 3, 2, 0);
    go("lw3",      0, 0, 0, 2);
    ins(0, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    go("yng_stl",  1, 0, 0, 2);
    go("yng_go",   0, 0, 0, 3);

    // Mult/div busy interlock with E bubbles
    idle();
    go("md_pre",   0, 0, 0, 3);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); bus.md_busy = 1'b1;
    go("md_b1",    1, 0, 0, 3);
    go("md_b2",    1, 0, 0, 4);
    go("md_b3",    1, 0, 0, 5);
    go("md_b4",    1, 0, 0, 6);
    bus.md_busy = 1'b0;
    go("md_rel",   0, 0, 0, 7);
    go("md_e",     1, 0, 0, 7);
    idle();
    go("md_idle",  0, 0, 0, 8);

    // Asynchronous reset in the middle of a two-cycle load stall
    ins(0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
    go("rlw1",     0, 0, 0, 8);
    ins(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    go("r_stl",    1, 0, 0, 8);
    reset = 1'b1;
    go("r_mid",    0, 0, 0, 0);
    reset = 1'b0;
    go("r_after",  0, 0, 0, 0);

    // Same scenario with flush: cleared one edge later
    ins(0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
    go("flw1",     0, 0, 0, 0);
    ins(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    go("f_stl",    1, 0, 0, 0);
    bus.flush = 1'b1;
    go("f_mid",    1, 0, 0, 1);
    bus.flush = 1'b0;
    go("f_after",  0, 0, 0, 2);

    // Flush beats loading a valid D instruction
    ins(0, 0, 0, 0, 0, 0, 1, 1, 2, 0); bus.flush = 1'b1;
    go("f_load",   0, 0, 0, 2);
    bus.flush = 1'b0;
    ins(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    go("f_nohaz",  0, 0, 0, 2);

    // Forward from E (tnew=0), then unused source ignores a match
    ins(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    go("wr6",      0, 0, 0, 2);
    ins(6, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    go("fwd_e",    0, 1, 0, 2);
    ins(6, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    go("use_off",  0, 0, 2, 2);

    // No stall without a valid D instruction
    ins(0, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    go("wr7",      0, 0, 0, 2);
    ins(7, 0, 1, 0, 0, 0, 0, 0, 0, 0); bus.d_valid = 1'b0;
    go("nvalid",   0, 0, 0, 2);
    idle();

    // Drain the scoreboard queue with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
